// File: rtl/accel_pkg.sv
// Shared types for the BRAM port-1 arbiter.
//   state_e    : arbiter FSM states
//   REQ_A/B    : requester IDs (also the bit index in two-bit request/grant vectors)
//   req_onehot : requester ID -> one-hot two-bit vector
package accel_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic [1:0] req_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational.
//   i_req  [1:0] : request vector (bit 0 = A, bit 1 = B)
//   i_last       : requester served most recently
//   o_gnt  [1:0] : one-hot grant (all zero when nothing requests)
module rr_arb2
  import accel_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    // On a tie the requester not served last wins.
    if (i_req == 2'b11) begin
      o_gnt = req_onehot(~i_last);
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Burst arbiter sharing BRAM port 1 between requester A (host DMA) and B (engine).
// One whole burst is granted at a time, round-robin on ties; the address stream
// auto-increments and wraps modulo DEPTH. Read beats return with rvalid one cycle
// after issue, matching the BRAM's registered read.
//   i_clk, i_rst_n              : clock, async active-low reset
//   i_x_req/we/addr/len         : burst request (x = a, b), held until o_x_gnt
//   o_x_gnt                     : burst accepted, beat 0 issued this cycle
//   i_x_wdata / o_x_wready      : write beat / write beat consumed
//   o_x_rdata / o_x_rvalid      : read beat / read beat valid
//   o_x_done                    : burst complete
//   o_bram_addr/wdata/we, i_bram_rdata : BRAM port 1
module bram_port_arbiter
  import accel_pkg::*;
#(
  parameter int unsigned WIDTH     = 72,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LOG_DEPTH = 9,
  parameter int unsigned LEN_W     = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_a_req,
  input  logic                 i_a_we,
  input  logic [LOG_DEPTH-1:0] i_a_addr,
  input  logic [LEN_W-1:0]     i_a_len,
  output logic                 o_a_gnt,
  input  logic [WIDTH-1:0]     i_a_wdata,
  output logic                 o_a_wready,
  output logic [WIDTH-1:0]     o_a_rdata,
  output logic                 o_a_rvalid,
  output logic                 o_a_done,
  input  logic                 i_b_req,
  input  logic                 i_b_we,
  input  logic [LOG_DEPTH-1:0] i_b_addr,
  input  logic [LEN_W-1:0]     i_b_len,
  output logic                 o_b_gnt,
  input  logic [WIDTH-1:0]     i_b_wdata,
  output logic                 o_b_wready,
  output logic [WIDTH-1:0]     o_b_rdata,
  output logic                 o_b_rvalid,
  output logic                 o_b_done,
  output logic [LOG_DEPTH-1:0] o_bram_addr,
  output logic [WIDTH-1:0]     o_bram_wdata,
  output logic                 o_bram_we,
  input  logic [WIDTH-1:0]     i_bram_rdata
);

  if (DEPTH != (2 ** LOG_DEPTH)) begin : g_depth_check
    $error("DEPTH must equal 2**LOG_DEPTH");
  end

  localparam logic [LOG_DEPTH-1:0] ADDR_ONE = LOG_DEPTH'(1);
  localparam logic [LEN_W-1:0]     CNT_ONE  = LEN_W'(1);

  state_e               r_state, w_state_d;
  logic                 r_owner, w_owner_d;
  logic                 r_we, w_we_d;
  logic [LOG_DEPTH-1:0] r_addr, w_addr_d;
  logic [LEN_W-1:0]     r_cnt, w_cnt_d;
  logic [LEN_W-1:0]     r_len, w_len_d;
  logic                 r_bram_we, w_bram_we_d;
  logic [1:0]           r_gnt, w_gnt_d;
  logic [1:0]           r_rvalid, w_rvalid_d;
  logic [1:0]           r_done, w_done_d;
  logic                 r_last, w_last_d;
  logic [1:0]           w_pick;
  logic                 w_wr_beat;

  rr_arb2 u_rr_arb2 (
    .i_req  ({i_b_req, i_a_req}),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  always_comb begin
    w_state_d   = r_state;
    w_owner_d   = r_owner;
    w_we_d      = r_we;
    w_addr_d    = r_addr;
    w_cnt_d     = r_cnt;
    w_len_d     = r_len;
    w_bram_we_d = r_bram_we;
    w_gnt_d     = 2'b00;
    w_done_d    = 2'b00;
    w_last_d    = r_last;
    // A read beat issued this cycle returns its data next cycle.
    w_rvalid_d  = ((r_state == StBurst) && !r_we) ? req_onehot(r_owner) : 2'b00;

    unique case (r_state)
      StIdle: begin
        if (|w_pick) begin
          w_state_d   = StBurst;
          w_owner_d   = w_pick[1];
          w_we_d      = w_pick[1] ? i_b_we : i_a_we;
          w_addr_d    = w_pick[1] ? i_b_addr : i_a_addr;
          w_len_d     = w_pick[1] ? i_b_len : i_a_len;
          w_cnt_d     = '0;
          w_bram_we_d = w_pick[1] ? i_b_we : i_a_we;
          w_gnt_d     = w_pick;
        end
      end
      StBurst: begin
        if (r_cnt == r_len) begin
          w_state_d   = StDrain;
          w_bram_we_d = 1'b0;
          w_done_d    = req_onehot(r_owner);
        end else begin
          w_addr_d = r_addr + ADDR_ONE;  // wraps modulo DEPTH
          w_cnt_d  = r_cnt + CNT_ONE;
        end
      end
      StDrain: begin
        w_state_d = StIdle;
        w_last_d  = r_owner;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_owner   <= REQ_A;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_bram_we <= 1'b0;
      r_gnt     <= 2'b00;
      r_rvalid  <= 2'b00;
      r_done    <= 2'b00;
      r_last    <= REQ_B;  // "B served last" makes A win the first tie
    end else begin
      r_state   <= w_state_d;
      r_owner   <= w_owner_d;
      r_we      <= w_we_d;
      r_addr    <= w_addr_d;
      r_cnt     <= w_cnt_d;
      r_len     <= w_len_d;
      r_bram_we <= w_bram_we_d;
      r_gnt     <= w_gnt_d;
      r_rvalid  <= w_rvalid_d;
      r_done    <= w_done_d;
      r_last    <= w_last_d;
    end
  end

  assign w_wr_beat    = (r_state == StBurst) && r_we;

  assign o_a_gnt      = r_gnt[0];
  assign o_b_gnt      = r_gnt[1];
  assign o_a_rvalid   = r_rvalid[0];
  assign o_b_rvalid   = r_rvalid[1];
  assign o_a_done     = r_done[0];
  assign o_b_done     = r_done[1];
  assign o_a_wready   = w_wr_beat && (r_owner == REQ_A);
  assign o_b_wready   = w_wr_beat && (r_owner == REQ_B);
  assign o_a_rdata    = i_bram_rdata;
  assign o_b_rdata    = i_bram_rdata;
  assign o_bram_addr  = r_addr;
  assign o_bram_we    = r_bram_we;
  assign o_bram_wdata = (r_owner == REQ_B) ? i_b_wdata : i_a_wdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_we, b_req, b_we;
  logic [8:0]  a_addr, b_addr, a_len, b_len;
  logic [71:0] a_wdata, b_wdata;
  logic        a_gnt, a_wready, a_rvalid, a_done;
  logic        b_gnt, b_wready, b_rvalid, b_done;
  logic [71:0] a_rdata, b_rdata;
  logic [8:0]  bram_addr;
  logic [71:0] bram_wdata;
  logic        bram_we;
  logic [71:0] bram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  bram_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_len(a_len), .o_a_gnt(a_gnt),
    .i_a_wdata(a_wdata), .o_a_wready(a_wready), .o_a_rdata(a_rdata),
    .o_a_rvalid(a_rvalid), .o_a_done(a_done),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_len(b_len), .o_b_gnt(b_gnt),
    .i_b_wdata(b_wdata), .o_b_wready(b_wready), .o_b_rdata(b_rdata),
    .o_b_rvalid(b_rvalid), .o_b_done(b_done),
    .o_bram_addr(bram_addr), .o_bram_wdata(bram_wdata), .o_bram_we(bram_we),
    .i_bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] init_word(input int i);
    return 72'h5A_0000_0000 + 72'(i) * 72'h101;
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endfunction

  function automatic void chkw(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // BRAM port 1 environment: registered read, contents seeded on the first edge.
  logic [71:0] ram [512];
  bit ram_ok = 0;
  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
      ram_ok <= 1'b1;
    end else if (bram_we) begin
      ram[bram_addr] <= bram_wdata;
    end
    bram_rdata <= ram[bram_addr];
  end

  // Observation log for the directed literal checks.
  int          rv_a_cnt = 0, rv_b_cnt = 0, done_a_cnt = 0;
  int          seen [512];
  logic [8:0]  prev_addr = '0;
  logic [8:0]  we_q [$];
  logic [71:0] rd_q [$];
  int          rdc_q [$];
  always @(negedge clk) begin
    if (a_done) done_a_cnt++;
    if (a_rvalid) rv_a_cnt++;
    if (b_rvalid) begin
      rv_b_cnt++;
      seen[prev_addr]++;
      rd_q.push_back(b_rdata);
      rdc_q.push_back(cyc);
    end
    if (bram_we) we_q.push_back(bram_addr);
    prev_addr = bram_addr;
  end

  // Transaction model: one active burst described by start cycle, base, length and owner.
  logic [71:0] m_mem [512];
  bit          m_act = 0, m_we = 0, m_own = 0, m_last = 1;
  int          m_s = 0, m_len = 0;
  logic [8:0]  m_base = '0;

  always @(negedge clk) begin : cmp
    bit          is_gnt, in_beat, in_rv, is_done;
    logic [8:0]  ea;
    logic [71:0] ew;
    if (chk_en) begin
      is_gnt  = m_act && cyc == m_s;
      in_beat = m_act && cyc >= m_s && cyc <= m_s + m_len;
      in_rv   = m_act && !m_we && cyc > m_s && cyc <= m_s + m_len + 1;
      is_done = m_act && cyc == m_s + m_len + 1;
      chk1("a_gnt", a_gnt, is_gnt && !m_own);
      chk1("b_gnt", b_gnt, is_gnt && m_own);
      chk1("a_wready", a_wready, in_beat && m_we && !m_own);
      chk1("b_wready", b_wready, in_beat && m_we && m_own);
      chk1("a_rvalid", a_rvalid, in_rv && !m_own);
      chk1("b_rvalid", b_rvalid, in_rv && m_own);
      chk1("a_done", a_done, is_done && !m_own);
      chk1("b_done", b_done, is_done && m_own);
      chk1("bram_we", bram_we, in_beat && m_we);
      if (in_beat) begin
        ea = m_base + 9'(cyc - m_s);
        chkw("bram_addr", 72'(bram_addr), 72'(ea));
        if (m_we) begin
          ew = m_own ? b_wdata : a_wdata;
          chkw("bram_wdata", bram_wdata, ew);
          m_mem[ea] = ew;
        end
      end
      if (in_rv) begin
        ea = m_base + 9'(cyc - m_s - 1);
        chkw("a_rdata", a_rdata, m_mem[ea]);
        chkw("b_rdata", b_rdata, m_mem[ea]);
      end
      if (is_done) m_last = m_own;
      if ((!m_act || cyc >= m_s + m_len + 2) && (a_req || b_req)) begin
        m_own  = (a_req && b_req) ? !m_last : b_req;
        m_act  = 1'b1;
        m_s    = cyc + 1;
        m_we   = m_own ? b_we : a_we;
        m_base = m_own ? b_addr : a_addr;
        m_len  = int'(m_own ? b_len : a_len);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input bit who, input logic [71:0] d);
    if (who) b_wdata = d;
    else a_wdata = d;
  endtask

  // Raise a request, wait for gnt, stream write data, return at the done cycle.
  task automatic burst(input bit who, input bit we, input logic [8:0] addr, input int len,
                       input logic [71:0] d0, output int gcyc, output int dcyc);
    bit got;
    int k;
    if (who) begin b_req = 1; b_we = we; b_addr = addr; b_len = 9'(len); end
    else     begin a_req = 1; a_we = we; a_addr = addr; a_len = 9'(len); end
    got = 0;
    for (int n = 0; n < 1500 && !got; n++) begin
      @(posedge clk); #1;
      if (who ? b_gnt : a_gnt) got = 1;
    end
    if (who) b_req = 0;
    else a_req = 0;
    chk1("gnt_seen", got, 1'b1);
    gcyc = cyc;
    k = 0;
    set_wdata(who, d0);
    got = 0;
    for (int n = 0; n < 1500 && !got; n++) begin
      if (who ? b_done : a_done) got = 1;
      else begin
        @(posedge clk); #1;
        k++;
        set_wdata(who, d0 + 72'(k));
      end
    end
    chk1("done_seen", got, 1'b1);
    dcyc = cyc;
  endtask

  initial begin
    int         c0, g1, d1, g2, d2, g3, d3, rv0, dn0, bad;
    int         seen0 [512];
    logic [8:0] exp_addr [4];
    bit         got;
    a_req = 0; a_we = 0; a_addr = '0; a_len = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_len = '0; b_wdata = '0;
    for (int i = 0; i < 512; i++) m_mem[i] = init_word(i);

    repeat (3) @(posedge clk); #1;
    chk1("rst_a_gnt", a_gnt, 1'b0);
    chk1("rst_b_gnt", b_gnt, 1'b0);
    chk1("rst_wready", a_wready | b_wready, 1'b0);
    chk1("rst_rvalid", a_rvalid | b_rvalid, 1'b0);
    chk1("rst_done", a_done | b_done, 1'b0);
    chk1("rst_bram_we", bram_we, 1'b0);
    chkw("rst_bram_addr", 72'(bram_addr), 72'd0);
    rst_n = 1; chk_en = 1;
    idle(2);

    // Contention from reset: A first, then B, then A's re-request loses to pending B.
    c0 = cyc;
    fork
      begin
        burst(0, 1, 9'h010, 2, 72'hC0, g1, d1);
        burst(0, 0, 9'h010, 1, 72'h0, g3, d3);
      end
      burst(1, 0, 9'h100, 1, 72'h0, g2, d2);
    join
    chki("cont_a_gnt_cycle", g1 - c0, 1);
    chki("cont_b_gnt_cycle", g2 - c0, 6);
    chki("cont_a2_gnt_cycle", g3 - c0, 10);
    idle(3);

    // Single write with address wrap.
    we_q.delete();
    c0 = cyc;
    burst(0, 1, 9'h1FE, 3, 72'hA0, g1, d1);
    chki("wr_gnt_cycle", g1 - c0, 1);
    chki("wr_done_cycle", d1 - c0, 5);
    chki("wr_beats", we_q.size(), 4);
    exp_addr[0] = 9'h1FE; exp_addr[1] = 9'h1FF; exp_addr[2] = 9'h000; exp_addr[3] = 9'h001;
    for (int i = 0; i < 4 && i < we_q.size(); i++)
      chkw("wr_addr_seq", 72'(we_q[i]), 72'(exp_addr[i]));
    idle(3);

    // Single read back by B.
    rd_q.delete(); rdc_q.delete();
    rv0 = rv_a_cnt;
    c0 = cyc;
    burst(1, 0, 9'h1FE, 3, 72'h0, g1, d1);
    idle(1);
    chki("rd_gnt_cycle", g1 - c0, 1);
    chki("rd_done_cycle", d1 - c0, 5);
    chki("rd_beats", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      chkw("rd_data", rd_q[i], 72'hA0 + 72'(i));
      chki("rd_rvalid_cycle", rdc_q[i] - c0, 2 + i);
    end
    chki("rd_a_rvalid_quiet", rv_a_cnt - rv0, 0);
    idle(2);

    // Minimum length.
    rv0 = rv_a_cnt;
    c0 = cyc;
    burst(0, 0, 9'h055, 0, 72'h0, g1, d1);
    idle(1);
    chki("len0_gnt_cycle", g1 - c0, 1);
    chki("len0_done_cycle", d1 - c0, 2);
    chki("len0_rvalids", rv_a_cnt - rv0, 1);
    idle(2);

    // Maximum length: every address exactly once.
    for (int i = 0; i < 512; i++) seen0[i] = seen[i];
    rv0 = rv_b_cnt;
    c0 = cyc;
    burst(1, 0, 9'h123, 511, 72'h0, g1, d1);
    idle(1);
    chki("len511_done_cycle", d1 - c0, 513);
    chki("len511_rvalids", rv_b_cnt - rv0, 512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (seen[i] - seen0[i] != 1) bad++;
    chki("len511_addr_once", bad, 0);
    idle(2);

    // Reset in the middle of a write burst.
    dn0 = done_a_cnt;
    a_req = 1; a_we = 1; a_addr = 9'h040; a_len = 9'd7;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #1;
      if (a_gnt) got = 1;
    end
    a_req = 0;
    chk1("rstmid_gnt_seen", got, 1'b1);
    a_wdata = 72'hE0;
    for (int k = 1; k < 3; k++) begin
      @(posedge clk); #1;
      a_wdata = 72'hE0 + 72'(k);
    end
    @(posedge clk); #1;
    chk1("rstmid_we_before", bram_we, 1'b1);
    chk_en = 0;
    rst_n = 0;
    #1;
    chk1("rstmid_bram_we_drop", bram_we, 1'b0);
    chk1("rstmid_wready_drop", a_wready, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
    m_act = 0; m_last = 1;
    chk_en = 1;
    #1;
    chk1("rel_gnt", a_gnt | b_gnt, 1'b0);
    chk1("rel_bram_we", bram_we, 1'b0);
    chk1("rel_done", a_done | b_done, 1'b0);
    chkw("rel_bram_addr", 72'(bram_addr), 72'd0);
    idle(2);
    chki("rstmid_no_done", done_a_cnt - dn0, 0);

    // Pointer back to "A first" after reset.
    c0 = cyc;
    fork
      burst(0, 1, 9'h0F0, 1, 72'hD0, g1, d1);
      burst(1, 0, 9'h0F0, 1, 72'h0, g2, d2);
    join
    chki("post_rst_a_gnt_cycle", g1 - c0, 1);
    chki("post_rst_b_gnt_cycle", g2 - c0, 5);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
